vram_sync_reader: RTL
=====================

# vram_sync_reader

Bulk VRAM read-out engine, the reading counterpart of the VRAM sync writer. On a one-cycle `sync` pulse it reads `WORDS` consecutive words from a VRAM read port, starting at a sampled base address, and streams them to a consumer over a valid/ready interface. It absorbs the fixed VRAM read latency and consumer back-pressure with a credit-limited output FIFO. It pulses `done` when the last word has been accepted.

## Interface
Parameters:
- `ADDR_W`, 11: VRAM word-address width.
- `DATA_W`, 32: VRAM word width.
- `WORDS`, 2048: words per transfer, 1..2^ADDR_W.
- `RD_LATENCY`, 2: cycles from `rd_en` to valid `rd_data`, ≥1.
- `FIFO_DEPTH`, 4: output FIFO entries, ≥ RD_LATENCY+1, power of 2.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `sync` input 1: start pulse; ignored while `busy`.
- `base_addr` input ADDR_W: start address, sampled on the cycle `sync` is accepted.
- `rd_en` output 1: VRAM read strobe.
- `rd_addr` output ADDR_W: VRAM read address.
- `rd_data` input DATA_W: VRAM read data, valid RD_LATENCY cycles after `rd_en`.
- `out_valid` output 1: stream word available.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `out_data` output DATA_W: stream word (FIFO head).
- `out_last` output 1: high with the final word of the transfer.
- `busy` output 1: transfer in progress, from the cycle after `sync` acceptance until `done`.
- `done` output 1: one-cycle pulse after the last word is accepted.

## Operation
- States are IDLE, READ, DRAIN and DONE.
  - IDLE → READ when `sync`=1. On this transition: latch `base_addr` into the address counter, clear the issue counter and the accept counter.
  - READ: issue a read (`rd_en`=1, `rd_addr`=addr counter) in each cycle where credits are available. The issue condition is (inflight + fifo_count) < FIFO_DEPTH.
    - Each issue increments the address, wrapping modulo 2^ADDR_W, and increments the issue count.
    - Move to DRAIN after issue number WORDS.
  - DRAIN: no reads. Move to DONE when accept count = WORDS.
  - DONE: `done`=1 for exactly one cycle, then go to IDLE. `sync` in DONE is ignored.
- Return path:
  - An RD_LATENCY-deep shift register of valid bits tracks in-flight reads.
  - When the tail bit is set, `rd_data` is pushed into the FIFO.
  - The credit rule guarantees the FIFO never overflows. Push data is never dropped, regardless of `out_ready`.
- Stream:
  - `out_valid` = FIFO not empty.
  - `out_last` = `out_valid` && (accept count = WORDS−1).
  - Accept count increments on each handshake.
  - `out_data`/`out_valid` are held stable while `out_valid && !out_ready`.
- Counter widths: issue and accept counters are $clog2(WORDS+1) bits, unsigned. The in-flight count is derived from the valid shift register.
- Simultaneous FIFO push and pop in one cycle is legal, including when the FIFO is full or empty. When empty, the pushed word appears at the head the next cycle; there is no combinational bypass.
- `sync` while `busy` has no effect: no restart, and no re-sampling of `base_addr`.
- Reset at any time, including mid-transfer:
  - Go to IDLE, empty the FIFO, clear the in-flight bits and all counters.
  - In-flight data is discarded.
  - Outputs reset to `rd_en`=0, `rd_addr`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, `done`=0.

## Timing
- Cycle 0 is the cycle `sync`=1 is sampled in IDLE.
- First `rd_en` is in cycle 1.
- First `rd_data` arrives in cycle 1+RD_LATENCY. The first `out_valid` is in cycle 2+RD_LATENCY.
- With `out_ready` held at 1, throughput is one word per cycle, with no bubbles:
  - last `rd_en` in cycle WORDS;
  - last handshake in cycle WORDS+1+RD_LATENCY;
  - `done` in cycle WORDS+2+RD_LATENCY.
  - With the defaults, `done` is in cycle 2052.
- `busy` is high in cycles 1 … WORDS+2+RD_LATENCY inclusive. A new `sync` is accepted the cycle after `done`.
- Back-pressure: after `out_ready` falls, at most FIFO_DEPTH words are buffered. `rd_en` stops within one cycle of credits reaching zero.

## Structure
- Package `vram_sync_pkg` holds:
  - the `vram_sync_rd_state_e` enum (IDLE, READ, DRAIN, DONE);
  - the localparam defaults for ADDR_W, DATA_W and WORDS, shared with the sync writer.
- Sub-module `vram_skid_fifo` (params DATA_W, FIFO_DEPTH):
  - synchronous FIFO with push, pop, head data, `count`, `empty` and `full`;
  - registered storage, with the same async active-low `rst_n`.
- Top level contains the FSM, address/issue/accept counters, in-flight shift register and credit logic.

## Test plan
- Basic transfer: VRAM model word n = n; `base_addr`=0; `sync` at cycle 0; `out_ready`=1.
  - Expect 2048 words 0…2047 on consecutive cycles 4…2051.
  - `out_last` only at cycle 2051; `done` at cycle 2052; `busy` is 0 afterwards.
- Wrap-around: `base_addr`=0x7FE, WORDS=4.
  - Expect `rd_addr` sequence 0x7FE, 0x7FF, 0x000, 0x001, and data in the same order.
- Back-pressure: `out_ready` toggles 1,0,0,1 repeating, FIFO_DEPTH=4.
  - No word is lost or duplicated; `out_data` is stable while stalled.
  - `rd_en` never makes (inflight + fifo_count) exceed 4.
  - `done` follows the 2048th handshake by one cycle.
- Ignored sync: pulse `sync` again at cycle 100 with a different `base_addr`.
  - The transfer is unchanged; `done` is still at cycle 2052.
  - A second `sync` at cycle 2053 starts a new transfer with its first `rd_en` at cycle 2054.
- Reset mid-transfer: assert `rst_n`=0 at cycle 500 with `out_ready`=0 and the FIFO full.
  - All outputs go to 0 immediately; the FSM is in IDLE.
  - A subsequent `sync` restarts cleanly from the new `base_addr`.
- Stall from start: hold `out_ready`=0 for 50 cycles after `sync`.
  - Exactly FIFO_DEPTH reads are issued, then `rd_en` stays 0.
  - On release, words 0,1,2,… stream in order.

Source files
------------

// File: rtl/vram_sync_pkg.sv
// Shared types and defaults for the VRAM sync writer/reader pair.
// Both engines default to the same VRAM geometry.
package vram_sync_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 32;
  localparam int VRAM_WORDS  = 2048;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN,
    RD_DONE
  } vram_sync_rd_state_e;

endpackage

// File: rtl/vram_sync_rd_if.sv
// VRAM read port plus valid/ready output stream of the sync reader.
// The master side is the reader engine.
interface vram_sync_rd_if
  import vram_sync_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/vram_skid_fifo.sv
// Small synchronous FIFO absorbing VRAM read latency and back-pressure.
// Head is registered storage; no push-to-head bypass.
module vram_skid_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  logic [DATA_W-1:0]                  push_data,
  input  logic                               pop,
  output logic [DATA_W-1:0]                  head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               empty,
  output logic                               full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     cnt;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + PW'(1);
      end
      if (do_pop)
        rptr <= rptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(FIFO_DEPTH));

endmodule

// File: rtl/vram_sync_reader.sv
// Bulk VRAM read-out engine: on sync, streams WORDS words from base_addr
// through a credit-limited FIFO and pulses done after the last accept.
module vram_sync_reader
  import vram_sync_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int WORDS      = VRAM_WORDS,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  vram_sync_rd_if.master    bus
);

  localparam int NW = $clog2(WORDS+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [NW-1:0] LAST = NW'(WORDS-1);

  vram_sync_rd_state_e state, state_nx;

  logic [ADDR_W-1:0]     addr_q;
  logic [NW-1:0]         issue_q;
  logic [NW-1:0]         acc_q;
  logic [RD_LATENCY-1:0] vld;

  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W-1:0] fifo_head;
  logic              credit;
  logic              issue;
  logic              fire;
  logic              start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + CW'(vld[i]);
  end

  // Reads in flight already own a FIFO slot, so the sum never exceeds depth.
  assign credit = !fifo_full &&
    (({1'b0, inflight} + {1'b0, fifo_cnt}) < (CW+1)'(FIFO_DEPTH));
  assign issue  = (state == RD_READ) && credit;
  assign fire   = !fifo_empty && bus.out_ready;
  assign start  = (state == RD_IDLE) && sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RD_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RD_IDLE:  if (sync) state_nx = RD_READ;
      RD_READ:  if (issue && issue_q == LAST) state_nx = RD_DRAIN;
      RD_DRAIN: if (fire && acc_q == LAST) state_nx = RD_DONE;
      RD_DONE:  state_nx = RD_IDLE;
      default:  state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      issue_q <= '0;
      acc_q   <= '0;
      vld     <= '0;
    end else begin
      if (start) begin
        addr_q  <= base_addr;
        issue_q <= '0;
      end else if (issue) begin
        addr_q  <= addr_q + ADDR_W'(1);
        issue_q <= issue_q + NW'(1);
      end
      if (start)     acc_q <= '0;
      else if (fire) acc_q <= acc_q + NW'(1);
      vld[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++)
        vld[i] <= vld[i-1];
    end
  end

  vram_skid_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld[RD_LATENCY-1]),
    .push_data (bus.rd_data),
    .pop       (fire),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_head;
  assign bus.out_last  = !fifo_empty && (acc_q == LAST);
  assign busy          = (state != RD_IDLE);
  assign done          = (state == RD_DONE);

endmodule
